// File: rtl/msrv32_bus_pkg.sv
// rtl/msrv32_bus_pkg.sv - shared AHB-lite-style encodings and responder state type
package msrv32_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  // Lanes with be=1 take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/msrv32_dmem_responder_if.sv
// rtl/msrv32_dmem_responder_if.sv - core data port bundle between msrv32 core and data memory
interface msrv32_dmem_responder_if;

  logic [31:0] dmaddr_in;
  logic [31:0] dmdata_in;
  logic        dmwr_req_in;
  logic [3:0]  dmwr_mask_in;
  logic [1:0]  data_htrans_in;
  logic [31:0] data_out;
  logic        data_hready_out;
  logic        hresp_out;

  modport master (
    output dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, data_htrans_in,
    input  data_out, data_hready_out, hresp_out
  );

  modport slave (
    input  dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, data_htrans_in,
    output data_out, data_hready_out, hresp_out
  );

endinterface

// File: rtl/msrv32_dmem_ram.sv
// rtl/msrv32_dmem_ram.sv - word RAM, byte-enabled synchronous write, combinational read
module msrv32_dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - data-memory slave: wait states, range error, write-to-read forwarding
module msrv32_dmem_responder
  import msrv32_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                      ms_riscv32_mp_clk_in,
  input  logic                      ms_riscv32_mp_rst_in,
  msrv32_dmem_responder_if.slave    dmem
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              wr_q, wr_d;
  logic [31:0]       data_q, data_d;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  bus_idx;
  logic              bus_in_range;
  logic              hready;
  logic              accept;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       ram_rdata;
  logic              fwd_hit;
  logic [31:0]       rd_merged;
  logic              unused_offset_lsbs;

  // Modulo-2^32 subtraction makes addresses below BASE_ADDR huge, hence out of range.
  assign offset             = dmem.dmaddr_in - BASE_ADDR;
  assign bus_idx            = offset[IDX_W+1:2];
  assign bus_in_range       = (offset[31:2] < 30'(DEPTH));
  assign unused_offset_lsbs = ^offset[1:0];

  assign hready = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept = hready && (dmem.data_htrans_in == HTRANS_NONSEQ);

  // A read launched from DATA races the commit of the write in that DATA cycle; merge it in.
  assign rd_idx    = (state_q == ST_WAIT) ? idx_q : bus_idx;
  assign fwd_hit   = (state_q == ST_DATA) && wr_q && (idx_q == rd_idx);
  assign rd_merged = fwd_hit ? merge_bytes(ram_rdata, wdata_q, mask_q) : ram_rdata;

  msrv32_dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (ms_riscv32_mp_clk_in),
    .we_i    ((state_q == ST_DATA) && wr_q),
    .be_i    (mask_q),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    data_d  = data_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d = ST_DATA;
          if (!wr_q) data_d = rd_merged;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      idx_d   = bus_idx;
      wdata_d = dmem.dmdata_in;
      mask_d  = dmem.dmwr_mask_in;
      wr_d    = dmem.dmwr_req_in;
      cnt_d   = 4'd0;
      if (!bus_in_range) begin
        state_d = ST_ERR1;
        data_d  = 32'h0;
      end else if (WAIT_STATES == 0) begin
        state_d = ST_DATA;
        if (!dmem.dmwr_req_in) data_d = rd_merged;
      end else begin
        state_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      wr_q    <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign dmem.data_hready_out = hready;
  assign dmem.hresp_out       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign dmem.data_out        = data_q;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - scoreboard bench for msrv32_dmem_responder
module tb_msrv32_dmem_responder;
  import msrv32_bus_pkg::*;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          waits;
  } sb_t;

  logic        clk;
  logic        rst0, rst1;
  logic [31:0] addr, wdata;
  logic        wr;
  logic [3:0]  mask;
  logic [1:0]  htrans;
  int          sel;

  int n_chk  = 0;
  int n_fail = 0;
  int accepted_cnt = 0;
  int done_cnt     = 0;
  int wait_cyc     = 0;
  bit wresp        = 0;
  sb_t sb_q[$];
  sb_t mon_e;

  msrv32_dmem_responder_if bus0 ();
  msrv32_dmem_responder_if bus1 ();

  assign bus0.dmaddr_in      = addr;
  assign bus0.dmdata_in      = wdata;
  assign bus0.dmwr_req_in    = wr;
  assign bus0.dmwr_mask_in   = mask;
  assign bus0.data_htrans_in = (sel != 1) ? htrans : HTRANS_IDLE;
  assign bus1.dmaddr_in      = addr;
  assign bus1.dmdata_in      = wdata;
  assign bus1.dmwr_req_in    = wr;
  assign bus1.dmwr_mask_in   = mask;
  assign bus1.data_htrans_in = (sel != 0) ? htrans : HTRANS_IDLE;

  msrv32_dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst0),
    .dmem                 (bus0.slave)
  );

  msrv32_dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) dut1 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst1),
    .dmem                 (bus1.slave)
  );

  logic        rdy, resp;
  logic [31:0] dout;
  assign rdy  = (sel == 1) ? bus1.data_hready_out : bus0.data_hready_out;
  assign resp = (sel == 1) ? bus1.hresp_out       : bus0.hresp_out;
  assign dout = (sel == 1) ? bus1.data_out        : bus0.data_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    if (m[0]) r[7:0]   = n[7:0];
    if (m[1]) r[15:8]  = n[15:8];
    if (m[2]) r[23:16] = n[23:16];
    if (m[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  // Called at a falling edge; returns at a falling edge with htrans back at IDLE.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input bit err, input logic [31:0] exp_rd, input bit hold);
    sb_t e;
    bit  pre;
    int  n;
    addr = a; wdata = d; wr = w; mask = m; htrans = HTRANS_NONSEQ;
    e.rd = !w; e.err = err; e.data = err ? 32'h0 : exp_rd;
    e.waits = err ? 1 : ((sel == 1) ? 3 : 0);
    sb_q.push_back(e);
    n = 0;
    forever begin
      pre = rdy;
      @(posedge clk);
      if (pre) break;
      @(negedge clk);
      n++;
      if (n > 40) begin
        check_eq("accept_timeout", 32'(n), 32'd0);
        void'(sb_q.pop_back());
        htrans = HTRANS_IDLE;
        return;
      end
    end
    accepted_cnt++;
    if (hold) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rdy && n < 40);
    end else begin
      @(negedge clk);
    end
    htrans = HTRANS_IDLE;
  endtask

  task automatic drain();
    int n;
    htrans = HTRANS_IDLE;
    n = 0;
    while (done_cnt != accepted_cnt && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain", 32'(done_cnt), 32'(accepted_cnt));
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (accepted_cnt != done_cnt) begin
      if (!rdy) begin
        wait_cyc++;
        if (resp) wresp = 1'b1;
      end else begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("waits", 32'(wait_cyc), 32'(mon_e.waits));
          check_eq("hresp", {31'd0, resp}, {31'd0, mon_e.err});
          check_eq("wait_hresp", {31'd0, wresp}, (mon_e.waits != 0) ? {31'd0, mon_e.err} : 32'd0);
          if (mon_e.rd) check_eq("rdata", dout, mon_e.data);
        end
        done_cnt++;
        wait_cyc = 0;
        wresp = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] v, d2;
    logic [3:0]  m;
    rst0 = 1'b0; rst1 = 1'b0; sel = 2;
    addr = 32'h0; wdata = 32'h0; wr = 1'b0; mask = 4'h0; htrans = HTRANS_IDLE;

    // Reset held with random bus activity
    repeat (4) begin
      @(negedge clk);
      addr = $urandom; wdata = $urandom; wr = 1'($urandom); mask = 4'($urandom); htrans = 2'($urandom);
      #1;
      check_eq("rst_rdy0", {31'd0, bus0.data_hready_out}, 32'd1);
      check_eq("rst_resp0", {31'd0, bus0.hresp_out}, 32'd0);
      check_eq("rst_dout0", bus0.data_out, 32'h0);
      check_eq("rst_rdy1", {31'd0, bus1.data_hready_out}, 32'd1);
      check_eq("rst_resp1", {31'd0, bus1.hresp_out}, 32'd0);
      check_eq("rst_dout1", bus1.data_out, 32'h0);
    end
    @(negedge clk);
    htrans = HTRANS_IDLE; rst0 = 1'b1; rst1 = 1'b1; sel = 0;
    @(negedge clk);
    check_eq("post_rst_rdy", {31'd0, rdy}, 32'd1);
    check_eq("post_rst_resp", {31'd0, resp}, 32'd0);

    // Zero wait states: back-to-back W/R, byte masks, forwarding
    xfer(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0);
    xfer(1, 32'h20, 32'h1122_3344, 4'hF, 0, 32'h0, 0);
    xfer(1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 0);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);
    xfer(1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 0);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);
    xfer(0, 32'h13, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0);
    drain();
    xfer(0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0);

    // Out of range: error response, RAM untouched (incl. word 0 that index 64 would alias)
    xfer(1, 32'hFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 0);
    xfer(1, 32'h00, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 0);
    xfer(0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 0);
    xfer(1, 32'h100, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 0);
    xfer(0, 32'hFC, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 0);
    xfer(0, 32'h00, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 0);

    // Random masked merges with forwarding
    for (int i = 0; i < 6; i++) begin
      v = $urandom; d2 = $urandom; m = 4'($urandom_range(0, 15));
      xfer(1, 32'((32 + i) * 4), v, 4'hF, 0, 32'h0, 0);
      xfer(1, 32'((32 + i) * 4), d2, m, 0, 32'h0, 0);
      xfer(0, 32'((32 + i) * 4), 32'h0, 4'h0, 0, exp_merge(v, d2, m), 0);
    end
    drain();

    // Three wait states, base 0x1000, 16 words
    sel = 1;
    @(negedge clk);
    xfer(1, 32'h1000, 32'h1234_5678, 4'hF, 0, 32'h0, 0);
    drain();
    xfer(0, 32'h1000, 32'h0, 4'h0, 0, 32'h1234_5678, 1);
    drain();
    repeat (3) begin
      @(negedge clk);
      check_eq("no_reaccept", {31'd0, rdy}, 32'd1);
    end
    xfer(1, 32'h1000, 32'h0000_FFFF, 4'b0011, 0, 32'h0, 0);
    xfer(0, 32'h1000, 32'h0, 4'h0, 0, 32'h1234_FFFF, 0);
    xfer(1, 32'h103C, 32'h5A5A_A5A5, 4'hF, 0, 32'h0, 0);
    xfer(0, 32'h0FFC, 32'h0, 4'h0, 1, 32'h0, 0);
    xfer(0, 32'h1040, 32'h0, 4'h0, 1, 32'h0, 0);
    xfer(1, 32'h1040, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 0);
    xfer(0, 32'h103C, 32'h0, 4'h0, 0, 32'h5A5A_A5A5, 0);
    xfer(1, 32'h1008, 32'h0101_0101, 4'hF, 0, 32'h0, 0);
    drain();

    // Reset in the middle of a write's wait states
    @(negedge clk);
    addr = 32'h1008; wdata = 32'hFFFF_FFFF; wr = 1'b1; mask = 4'hF; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    htrans = HTRANS_IDLE;
    check_eq("mid_wait_rdy", {31'd0, rdy}, 32'd0);
    rst1 = 1'b0;
    #1;
    check_eq("abort_rdy", {31'd0, rdy}, 32'd1);
    check_eq("abort_resp", {31'd0, resp}, 32'd0);
    check_eq("abort_dout", dout, 32'h0);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    xfer(0, 32'h1008, 32'h0, 4'h0, 0, 32'h0101_0101, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
